dds_sweep_controller: RTL and testbench
=======================================

Name: dds_sweep_controller

Overview:
Sequences the frequency control word (phase increment) driven into the waveform generator's phase accumulator. It produces a stepped linear frequency sweep from a start FCW to a stop FCW. Each FCW is held for a programmable dwell time, with optional continuous repeat. It sits between the register/config interface and the accumulator's i_count_value input. Its output is 0 whenever it is idle, so the accumulator phase freezes.

Parameters:
DEPTH, 1024, phase table depth; phase/FCW width PW = $clog2(DEPTH)
DWELL_W, 16, width of dwell counter

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; asynchronous, active-low
i_start  in  1  single-cycle sweep start request; sampled only in IDLE
i_abort  in  1  stop the sweep immediately; priority over all other inputs
i_continuous  in  1  1: restart from start FCW after reaching stop; sampled at start
i_fcw_start  in  PW  first FCW of the sweep
i_fcw_stop  in  PW  last FCW of the sweep
i_fcw_step  in  PW  FCW increment per step
i_dwell  in  DWELL_W  cycles held at each FCW; 0 is treated as 1
o_count_value  out  PW  FCW to the phase accumulator
o_busy  out  1  sweep in progress
o_step  out  1  1-cycle pulse in the cycle a new FCW (not the first) appears
o_done  out  1  1-cycle pulse at normal sweep completion
o_err  out  1  1-cycle pulse when start is rejected due to bad configuration

Behaviour:
- Reset (asynchronous): state=IDLE, o_count_value=0, o_busy=0, o_step=0, o_done=0, o_err=0, all shadow registers and the dwell counter =0.
- All outputs are registered.
- States: IDLE, DWELL, DONE.
- IDLE, i_start=1 (edge k):
  - If i_fcw_step==0 or i_fcw_start>i_fcw_stop: o_err=1 for one cycle after edge k; stay IDLE.
  - Otherwise: latch start/stop/step/dwell/continuous into shadow registers. After edge k: o_count_value=i_fcw_start, o_busy=1, dwell counter=max(i_dwell,1)-1, state=DWELL.
- The shadow registers are used for the rest of the sweep. Input changes during a sweep have no effect.
- DWELL: counter decrements each cycle. When counter==0 at an edge:
  - Compute next = cur + step in PW+1 bits (no wrap).
  - If cur==stop: go to DONE (or restart, see continuous mode below).
  - Else if next > stop: cur <= stop (clamped final step), o_step=1, reload counter.
  - Else: cur <= next, o_step=1, reload counter.
- Each FCW is therefore held for exactly max(dwell,1) cycles.
- DONE: lasts one cycle, with o_count_value=0, o_busy=0, o_done=1. Next state is IDLE.
- Continuous mode: when cur==stop expires, cur <= start and the counter reloads. o_step=1 on this restart. No DONE state and no o_done pulse.
- i_abort=1 in any state: the next edge gives IDLE, o_count_value=0, o_busy=0, and no o_done, o_step or o_err pulse.
- i_abort and i_start in the same cycle: abort wins and the sweep does not start.
- i_start while busy or in DONE: ignored. A new start is accepted in IDLE only, i.e. the earliest acceptance is the cycle after DONE.
- start==stop: single FCW held for dwell cycles, then DONE.
- Reset asserted mid-sweep: outputs go to their reset values immediately, with no done pulse.

Test Plan:
1. DEPTH=1024; start=10, stop=40, step=10, dwell=3; pulse i_start at edge 0 -> o_count_value is 10,10,10,20,20,20,30,30,30,40,40,40 over cycles 1-12. o_step pulses at cycles 4, 7, 10. Cycle 13: o_done=1, o_busy=0, o_count_value=0.
2. start=10, stop=35, step=10, dwell=1 -> sequence 10, 20, 30, 35 (clamped); o_done at cycle 5. Then start=1000, stop=1023, step=20 -> 1000, 1020, 1023, with no wrap past 1023.
3. start=50, stop=40 or step=0 -> o_err=1 for one cycle; o_busy stays 0 and o_count_value stays 0.
4. dwell=0, start=stop=7 -> o_count_value=7 for one cycle, then o_done. Change the config inputs mid-sweep -> the sequence is unaffected.
5. Scenario 1 config with i_abort at cycle 5 -> o_count_value=0 and o_busy=0 from cycle 6, no o_done. Abort and start in the same cycle -> remains idle.
6. i_continuous=1 with scenario 1 config -> after 40 is held 3 cycles, returns to 10 with an o_step pulse and no o_done. A second i_start while busy is ignored.

Source files
------------

// File: rtl/dds_sweep_controller.sv
// rtl/dds_sweep_controller.sv - stepped linear FCW sweep sequencer for the DDS phase accumulator
// Holds each FCW for a programmable dwell, clamps the last step to the stop FCW, optional repeat.
module dds_sweep_controller #(
   parameter int DEPTH   = 1024,
   parameter int DWELL_W = 16,
   localparam int PW     = $clog2(DEPTH)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic               i_continuous,
   input  logic [PW-1:0]      i_fcw_start,
   input  logic [PW-1:0]      i_fcw_stop,
   input  logic [PW-1:0]      i_fcw_step,
   input  logic [DWELL_W-1:0] i_dwell,
   output logic [PW-1:0]      o_count_value,
   output logic               o_busy,
   output logic               o_step,
   output logic               o_done,
   output logic               o_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DWELL = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [PW-1:0]      start_sh, stop_sh, step_sh;
   logic [DWELL_W-1:0] dwell_sh, cnt;
   logic               cont_sh;

   logic [PW-1:0]      count_nxt;
   logic [DWELL_W-1:0] cnt_nxt, reload, first_load;
   logic               busy_nxt, step_nxt, done_nxt, err_nxt, load;
   logic               cfg_ok, expired, at_stop;
   logic [PW:0]        next_sum;

   assign cfg_ok     = (i_fcw_step != '0) && (i_fcw_start <= i_fcw_stop);
   assign expired    = (cnt == '0);
   assign at_stop    = (o_count_value == stop_sh);
   // One extra bit so a step past the top of the table is seen as overshoot, not a wrap.
   assign next_sum   = {1'b0, o_count_value} + {1'b0, step_sh};
   assign reload     = (dwell_sh == '0) ? '0 : dwell_sh - DWELL_W'(1);
   assign first_load = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= S_IDLE;
         start_sh      <= '0;
         stop_sh       <= '0;
         step_sh       <= '0;
         dwell_sh      <= '0;
         cont_sh       <= 1'b0;
         cnt           <= '0;
         o_count_value <= '0;
         o_busy        <= 1'b0;
         o_step        <= 1'b0;
         o_done        <= 1'b0;
         o_err         <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         o_count_value <= count_nxt;
         o_busy        <= busy_nxt;
         o_step        <= step_nxt;
         o_done        <= done_nxt;
         o_err         <= err_nxt;
         if (load) begin
            start_sh <= i_fcw_start;
            stop_sh  <= i_fcw_stop;
            step_sh  <= i_fcw_step;
            dwell_sh <= i_dwell;
            cont_sh  <= i_continuous;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      if (i_abort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (i_start && cfg_ok) state_nxt = S_DWELL;
            S_DWELL: if (expired && at_stop && !cont_sh) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      count_nxt = o_count_value;
      cnt_nxt   = cnt;
      busy_nxt  = o_busy;
      step_nxt  = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      load      = 1'b0;
      if (i_abort) begin
         count_nxt = '0;
         busy_nxt  = 1'b0;
         cnt_nxt   = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  if (cfg_ok) begin
                     load      = 1'b1;
                     count_nxt = i_fcw_start;
                     busy_nxt  = 1'b1;
                     cnt_nxt   = first_load;
                  end else begin
                     err_nxt = 1'b1;
                  end
               end
            end
            S_DWELL: begin
               if (!expired) begin
                  cnt_nxt = cnt - DWELL_W'(1);
               end else if (at_stop) begin
                  if (cont_sh) begin
                     count_nxt = start_sh;
                     step_nxt  = 1'b1;
                     cnt_nxt   = reload;
                  end else begin
                     count_nxt = '0;
                     busy_nxt  = 1'b0;
                     done_nxt  = 1'b1;
                  end
               end else begin
                  count_nxt = (next_sum > {1'b0, stop_sh}) ? stop_sh : next_sum[PW-1:0];
                  step_nxt  = 1'b1;
                  cnt_nxt   = reload;
               end
            end
            S_DONE: begin
               count_nxt = '0;
               busy_nxt  = 1'b0;
            end
            default: begin
               count_nxt = '0;
               busy_nxt  = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dds_sweep_controller.sv
// tb/tb_dds_sweep_controller.sv - bench for dds_sweep_controller
// Expected output stream is built per sweep from the FCW list; one process compares every cycle.
module tb_dds_sweep_controller;
   localparam int DEPTH   = 1024;
   localparam int DWELL_W = 16;
   localparam int PW      = 10;

   logic               i_clk = 1'b0;
   logic               i_rst_n = 1'b1;
   logic               i_start = 1'b0;
   logic               i_abort = 1'b0;
   logic               i_continuous = 1'b0;
   logic [PW-1:0]      i_fcw_start = '0;
   logic [PW-1:0]      i_fcw_stop = '0;
   logic [PW-1:0]      i_fcw_step = '0;
   logic [DWELL_W-1:0] i_dwell = '0;
   logic [PW-1:0]      o_count_value;
   logic               o_busy, o_step, o_done, o_err;

   dds_sweep_controller #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
      .i_continuous(i_continuous), .i_fcw_start(i_fcw_start), .i_fcw_stop(i_fcw_stop),
      .i_fcw_step(i_fcw_step), .i_dwell(i_dwell), .o_count_value(o_count_value),
      .o_busy(o_busy), .o_step(o_step), .o_done(o_done), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [PW-1:0] cv;
      logic          busy;
      logic          step;
      logic          done;
      logic          err;
   } exp_t;

   exp_t q[$];
   exp_t e_cur, got;
   int   tests = 0;
   int   fails = 0;
   bit   chk_en = 1'b0;
   bit   exp_idle = 1'b1;

   task automatic push(input int cv, input bit b, input bit st, input bit d, input bit er);
      exp_t x;
      x.cv = PW'(cv); x.busy = b; x.step = st; x.done = d; x.err = er;
      q.push_back(x);
   endtask

   // Cycle-by-cycle outputs of one sweep, derived from its list of FCWs.
   task automatic model_start(input int s, input int e, input int st, input int dw, input bit cont);
      int d, f;
      bit first;
      if (st == 0 || s > e) begin
         push(0, 0, 0, 0, 1);
         return;
      end
      d = (dw == 0) ? 1 : dw;
      first = 1'b1;
      for (int lap = 0; lap < (cont ? 2 : 1); lap++) begin
         f = s;
         forever begin
            for (int i = 0; i < d; i++) push(f, 1, (i == 0 && !first), 0, 0);
            first = 1'b0;
            if (f == e) break;
            f = (f + st > e) ? e : f + st;
         end
      end
      if (!cont) push(0, 0, 0, 1, 0);
   endtask

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   always @(posedge i_clk) begin
      #2;
      if (chk_en) begin
         e_cur = (q.size() > 0) ? q.pop_front() : '0;
         exp_idle = !(e_cur.busy || e_cur.done);
         got = {o_count_value, o_busy, o_step, o_done, o_err};
         tests++;
         if (got !== e_cur) begin
            fails++;
            $display("FAIL cycle_compare t=%0t actual cv=%0d busy=%0b step=%0b done=%0b err=%0b required cv=%0d busy=%0b step=%0b done=%0b err=%0b",
                     $time, got.cv, got.busy, got.step, got.done, got.err,
                     e_cur.cv, e_cur.busy, e_cur.step, e_cur.done, e_cur.err);
         end
      end
   end

   task automatic launch(input int s, input int e, input int st, input int dw, input bit cont, input bit ab);
      @(negedge i_clk);
      i_fcw_start = PW'(s); i_fcw_stop = PW'(e); i_fcw_step = PW'(st);
      i_dwell = DWELL_W'(dw); i_continuous = cont; i_start = 1'b1; i_abort = ab;
      if (ab) q.delete();
      else if (exp_idle) model_start(s, e, st, dw, cont);
      @(negedge i_clk);
      i_start = 1'b0; i_abort = 1'b0;
   endtask

   task automatic do_abort();
      i_abort = 1'b1;
      q.delete();
      @(negedge i_clk);
      i_abort = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || !exp_idle) && n < 300) begin
         @(negedge i_clk);
         n++;
      end
      if (n >= 300) check("drain_timeout", 1, 0);
      @(negedge i_clk);
   endtask

   initial begin
      #1 i_rst_n = 1'b0;
      #11;
      check("reset_cv", int'(o_count_value), 0);
      check("reset_busy", int'(o_busy), 0);
      check("reset_step", int'(o_step), 0);
      check("reset_done", int'(o_done), 0);
      check("reset_err", int'(o_err), 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(negedge i_clk);

      // basic sweep 10..40 step 10 dwell 3
      launch(10, 40, 10, 3, 0, 0);
      check("model_len_s1", q.size(), 12);
      check("s1_c1_cv", int'(o_count_value), 10);
      repeat (3) @(negedge i_clk);
      check("s1_c4_cv", int'(o_count_value), 20);
      check("s1_c4_step", int'(o_step), 1);
      repeat (9) @(negedge i_clk);
      check("s1_c13_done", int'(o_done), 1);
      check("s1_c13_busy", int'(o_busy), 0);
      check("s1_c13_cv", int'(o_count_value), 0);
      drain();

      // clamped last step
      launch(10, 35, 10, 1, 0, 0);
      check("s2_c1_cv", int'(o_count_value), 10);
      repeat (3) @(negedge i_clk);
      check("s2_c4_cv", int'(o_count_value), 35);
      drain();
      launch(1000, 1023, 20, 1, 0, 0);
      repeat (2) @(negedge i_clk);
      check("s2b_c3_cv", int'(o_count_value), 1023);
      drain();

      // bad configurations
      launch(50, 40, 10, 3, 0, 0);
      check("s3_err", int'(o_err), 1);
      check("s3_busy", int'(o_busy), 0);
      drain();
      launch(10, 40, 0, 3, 0, 0);
      check("s3b_err", int'(o_err), 1);
      drain();

      // zero dwell, single FCW
      launch(7, 7, 5, 0, 0, 0);
      check("s4_c1_cv", int'(o_count_value), 7);
      @(negedge i_clk);
      check("s4_c2_done", int'(o_done), 1);
      drain();

      // config inputs change mid-sweep
      launch(10, 40, 10, 3, 0, 0);
      i_fcw_start = '0; i_fcw_stop = 10'd1023; i_fcw_step = 10'd1; i_dwell = 16'd1; i_continuous = 1'b1;
      drain();

      // abort at cycle 5
      launch(10, 40, 10, 3, 0, 0);
      repeat (4) @(negedge i_clk);
      do_abort();
      check("s5_abort_cv", int'(o_count_value), 0);
      check("s5_abort_busy", int'(o_busy), 0);
      drain();
      launch(10, 40, 10, 3, 0, 1);
      check("s5b_busy", int'(o_busy), 0);
      repeat (3) @(negedge i_clk);
      drain();

      // continuous mode, second start while busy
      launch(10, 40, 10, 3, 1, 0);
      repeat (3) @(negedge i_clk);
      launch(100, 200, 1, 1, 0, 0);
      repeat (7) @(negedge i_clk);
      check("s6_c13_cv", int'(o_count_value), 10);
      check("s6_c13_step", int'(o_step), 1);
      check("s6_c13_done", int'(o_done), 0);
      repeat (6) @(negedge i_clk);
      do_abort();
      drain();

      // reset mid-sweep
      launch(10, 40, 10, 3, 0, 0);
      repeat (2) @(negedge i_clk);
      chk_en = 1'b0;
      q.delete();
      i_rst_n = 1'b0;
      #1;
      check("rst_mid_cv", int'(o_count_value), 0);
      check("rst_mid_busy", int'(o_busy), 0);
      check("rst_mid_done", int'(o_done), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
